// File: rtl/matmul_pkg.sv
// Shared geometry, derived loop bounds and FSM encoding for the matmul tile scheduler.
package matmul_pkg;

    // Width helper: never returns 0 so single-value counters still get a 1-bit port.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    localparam int unsigned A_OUTER_DIMENSION = 8;
    localparam int unsigned B_OUTER_DIMENSION = 8;
    localparam int unsigned INNER_DIMENSION   = 64;
    localparam int unsigned BLOCK_SIZE        = 2;
    localparam int unsigned CHUNK_SIZE        = 4;
    localparam int unsigned NUM_CORES_A       = 2;
    localparam int unsigned NUM_CORES_B       = 2;
    localparam int unsigned NUM_HEADS         = 2;
    localparam int unsigned RD_LATENCY        = 2;

    localparam int unsigned K_STEPS      = INNER_DIMENSION / CHUNK_SIZE;
    localparam int unsigned TA           = A_OUTER_DIMENSION / (BLOCK_SIZE * NUM_CORES_A);
    localparam int unsigned TB           = B_OUTER_DIMENSION / (BLOCK_SIZE * NUM_CORES_B);
    localparam int unsigned ADDR_WIDTH_A = clog2_min1(TA * K_STEPS);
    localparam int unsigned ADDR_WIDTH_B = clog2_min1(NUM_HEADS * TB * K_STEPS);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } sched_state_e;

endpackage

// File: rtl/sched_delay_line.sv
// Fixed-depth shift register that aligns issue-time tags with returned read data.
module sched_delay_line #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/matmul_tile_sched.sv
// Walks head/tile/k loops, issues BRAM reads under backpressure and tags returning data
// with accumulator clear/last markers and tile identifiers.
module matmul_tile_sched #(
    parameter int unsigned A_OUTER_DIMENSION = matmul_pkg::A_OUTER_DIMENSION,
    parameter int unsigned B_OUTER_DIMENSION = matmul_pkg::B_OUTER_DIMENSION,
    parameter int unsigned INNER_DIMENSION   = matmul_pkg::INNER_DIMENSION,
    parameter int unsigned BLOCK_SIZE        = matmul_pkg::BLOCK_SIZE,
    parameter int unsigned CHUNK_SIZE        = matmul_pkg::CHUNK_SIZE,
    parameter int unsigned NUM_CORES_A       = matmul_pkg::NUM_CORES_A,
    parameter int unsigned NUM_CORES_B       = matmul_pkg::NUM_CORES_B,
    parameter int unsigned NUM_HEADS         = matmul_pkg::NUM_HEADS,
    parameter int unsigned RD_LATENCY        = matmul_pkg::RD_LATENCY,
    localparam int unsigned K_STEPS      = INNER_DIMENSION / CHUNK_SIZE,
    localparam int unsigned TA           = A_OUTER_DIMENSION / (BLOCK_SIZE * NUM_CORES_A),
    localparam int unsigned TB           = B_OUTER_DIMENSION / (BLOCK_SIZE * NUM_CORES_B),
    localparam int unsigned ADDR_WIDTH_A = matmul_pkg::clog2_min1(TA * K_STEPS),
    localparam int unsigned ADDR_WIDTH_B = matmul_pkg::clog2_min1(NUM_HEADS * TB * K_STEPS),
    localparam int unsigned HEAD_W       = matmul_pkg::clog2_min1(NUM_HEADS),
    localparam int unsigned TA_W         = matmul_pkg::clog2_min1(TA),
    localparam int unsigned TB_W         = matmul_pkg::clog2_min1(TB)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    mode,
    input  logic                    issue_ready,
    output logic                    rd_en,
    output logic [ADDR_WIDTH_A-1:0] addr_a,
    output logic [ADDR_WIDTH_B-1:0] addr_b,
    output logic                    data_valid,
    output logic                    acc_clr,
    output logic                    acc_last,
    output logic [HEAD_W-1:0]       head_idx,
    output logic [TA_W-1:0]         ta_idx,
    output logic [TB_W-1:0]         tb_idx,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned KW      = matmul_pkg::clog2_min1(K_STEPS);
    localparam int unsigned DRAIN_W = matmul_pkg::clog2_min1(RD_LATENCY + 1);
    localparam int unsigned PW      = 3 + HEAD_W + TA_W + TB_W;

    if ((INNER_DIMENSION % CHUNK_SIZE) != 0) begin : g_bad_k
        $error("INNER_DIMENSION must be a multiple of CHUNK_SIZE");
    end
    if ((A_OUTER_DIMENSION % (BLOCK_SIZE * NUM_CORES_A)) != 0) begin : g_bad_ta
        $error("A_OUTER_DIMENSION must be a multiple of BLOCK_SIZE*NUM_CORES_A");
    end
    if ((B_OUTER_DIMENSION % (BLOCK_SIZE * NUM_CORES_B)) != 0) begin : g_bad_tb
        $error("B_OUTER_DIMENSION must be a multiple of BLOCK_SIZE*NUM_CORES_B");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
        $error("RD_LATENCY must lie in 1..4");
    end

    matmul_pkg::sched_state_e state_q, state_d;

    logic                    mode_q, mode_d;
    logic [KW-1:0]           k_q, k_d;
    logic [TA_W-1:0]         ta_q, ta_d;
    logic [TB_W-1:0]         tb_q, tb_d;
    logic [HEAD_W-1:0]       head_q, head_d;
    logic [DRAIN_W-1:0]      drain_q, drain_d;
    logic [ADDR_WIDTH_A-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH_B-1:0] addr_b_q, addr_b_d;
    logic [PW-1:0]           iss_q, iss_d;
    logic [PW-1:0]           pipe_out;
    logic                    issue;

    logic k_wrap, ta_wrap, tb_wrap, head_wrap, inner_wrap, last_issue;

    assign k_wrap     = (k_q == KW'(K_STEPS - 1));
    assign ta_wrap    = (ta_q == TA_W'(TA - 1));
    assign tb_wrap    = (tb_q == TB_W'(TB - 1));
    assign head_wrap  = (head_q == HEAD_W'(NUM_HEADS - 1));
    assign inner_wrap = mode_q ? ta_wrap : tb_wrap;
    assign last_issue = k_wrap & ta_wrap & tb_wrap & head_wrap;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        k_d      = k_q;
        ta_d     = ta_q;
        tb_d     = tb_q;
        head_d   = head_q;
        drain_d  = drain_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        issue    = 1'b0;

        unique case (state_q)
            matmul_pkg::StIdle: begin
                if (start) begin
                    state_d = matmul_pkg::StRun;
                    mode_d  = mode;
                    k_d     = '0;
                    ta_d    = '0;
                    tb_d    = '0;
                    head_d  = '0;
                end
            end
            matmul_pkg::StRun: begin
                if (issue_ready) begin
                    issue    = 1'b1;
                    addr_a_d = ADDR_WIDTH_A'(32'(ta_q) * K_STEPS + 32'(k_q));
                    addr_b_d = ADDR_WIDTH_B'((32'(head_q) * TB + 32'(tb_q)) * K_STEPS
                                             + 32'(k_q));
                    if (last_issue) begin
                        state_d = matmul_pkg::StDrain;
                        drain_d = '0;
                        k_d     = '0;
                        ta_d    = '0;
                        tb_d    = '0;
                        head_d  = '0;
                    end else if (!k_wrap) begin
                        k_d = k_q + 1'b1;
                    end else begin
                        k_d = '0;
                        if (!inner_wrap) begin
                            if (mode_q) ta_d = ta_q + 1'b1;
                            else        tb_d = tb_q + 1'b1;
                        end else if (mode_q) begin
                            ta_d = '0;
                            if (!tb_wrap) tb_d = tb_q + 1'b1;
                            else begin
                                tb_d   = '0;
                                head_d = head_q + 1'b1;
                            end
                        end else begin
                            tb_d = '0;
                            if (!ta_wrap) ta_d = ta_q + 1'b1;
                            else begin
                                ta_d   = '0;
                                head_d = head_q + 1'b1;
                            end
                        end
                    end
                end
            end
            matmul_pkg::StDrain: begin
                // Wait until the final read's data has surfaced from the pipeline.
                if (drain_q == DRAIN_W'(RD_LATENCY)) state_d = matmul_pkg::StDone;
                else                                 drain_d = drain_q + 1'b1;
            end
            matmul_pkg::StDone: state_d = matmul_pkg::StIdle;
            default:            state_d = matmul_pkg::StIdle;
        endcase

        if (abort) begin
            state_d  = matmul_pkg::StIdle;
            issue    = 1'b0;
            k_d      = '0;
            ta_d     = '0;
            tb_d     = '0;
            head_d   = '0;
            drain_d  = '0;
            addr_a_d = '0;
            addr_b_d = '0;
        end

        iss_d = issue ? {1'b1, (k_q == '0), k_wrap, head_q, ta_q, tb_q} : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= matmul_pkg::StIdle;
            mode_q   <= 1'b0;
            k_q      <= '0;
            ta_q     <= '0;
            tb_q     <= '0;
            head_q   <= '0;
            drain_q  <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            iss_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            k_q      <= k_d;
            ta_q     <= ta_d;
            tb_q     <= tb_d;
            head_q   <= head_d;
            drain_q  <= drain_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            iss_q    <= iss_d;
        end
    end

    sched_delay_line #(
        .DEPTH (RD_LATENCY),
        .WIDTH (PW)
    ) u_delay (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (abort),
        .d_i    (iss_q),
        .q_o    (pipe_out)
    );

    assign rd_en  = iss_q[PW-1];
    assign addr_a = addr_a_q;
    assign addr_b = addr_b_q;
    assign {data_valid, acc_clr, acc_last, head_idx, ta_idx, tb_idx} = pipe_out;
    assign busy   = (state_q == matmul_pkg::StRun) || (state_q == matmul_pkg::StDrain);
    assign done   = (state_q == matmul_pkg::StDone);

endmodule

// File: tb/tb_matmul_tile_sched.sv
// Randomized self-checking bench: nested-loop read model, latency, backpressure, abort, reset.
module tb_matmul_tile_sched;
    import matmul_pkg::*;

    localparam int N_READS = NUM_HEADS * TA * TB * K_STEPS;
    localparam int HW  = clog2_min1(NUM_HEADS);
    localparam int TAW = clog2_min1(TA);
    localparam int TBW = clog2_min1(TB);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, mode = 1'b0, issue_ready = 1'b0;
    logic rd_en, data_valid, acc_clr, acc_last, busy, done;
    logic [ADDR_WIDTH_A-1:0] addr_a;
    logic [ADDR_WIDTH_B-1:0] addr_b;
    logic [HW-1:0]  head_idx;
    logic [TAW-1:0] ta_idx;
    logic [TBW-1:0] tb_idx;

    matmul_tile_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .issue_ready (issue_ready),
        .rd_en       (rd_en),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .data_valid  (data_valid),
        .acc_clr     (acc_clr),
        .acc_last    (acc_last),
        .head_idx    (head_idx),
        .ta_idx      (ta_idx),
        .tb_idx      (tb_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct { int a; int b; int clr; int last; int h; int ta; int tb; } rd_t;
    rd_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected read order straight from the loop nest: head, outer tile, inner tile, k.
    task automatic build_expected(input int md);
        int n_outer, n_inner;
        exp_q.delete();
        n_outer = md ? TB : TA;
        n_inner = md ? TA : TB;
        for (int h = 0; h < NUM_HEADS; h++)
            for (int o = 0; o < n_outer; o++)
                for (int i = 0; i < n_inner; i++)
                    for (int k = 0; k < K_STEPS; k++) begin
                        rd_t e;
                        e.ta   = md ? i : o;
                        e.tb   = md ? o : i;
                        e.h    = h;
                        e.a    = e.ta * K_STEPS + k;
                        e.b    = (h * TB + e.tb) * K_STEPS + k;
                        e.clr  = (k == 0);
                        e.last = (k == K_STEPS - 1);
                        exp_q.push_back(e);
                    end
    endtask

    function automatic logic next_ready(input int m, input int s);
        if (m == 0) return 1'b1;
        if (m == 1) return (s % 2) == 1;
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_rd_en"}, rd_en, 0);
        check_eq({tag, "_dv"}, data_valid, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    // rdy_mode: 0 always ready, 1 toggling, 2 random. abort_at/rst_at: read count, -1 = off.
    task automatic run_job(input int md, input int rdy_mode, input int abort_at,
                           input int rst_at, input int restart_s);
        int rd_n = 0, dv_n = 0, done_n = 0;
        int first_s = -1, last_s = -1, done_s = -1, kill_s = -1;
        bit use_rst = 1'b0, fin = 1'b0;
        int hist[$];
        build_expected(md);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b0;
        mode  = md[0];
        issue_ready = next_ready(rdy_mode, 0);
        for (int s = 1; s <= 1500 && !fin; s++) begin
            @(negedge clk);
            hist.push_back(int'(rd_en));
            if (kill_s >= 0 && s >= kill_s) begin
                check_quiet("after_kill");
                if (use_rst && s == kill_s + 2) rst_n = 1'b1;
                if (s >= kill_s + 8) fin = 1'b1;
            end else begin
                if (s == 1) check_eq("busy_after_start", busy, 1);
                if (rd_en) begin
                    if (first_s < 0) first_s = s;
                    last_s = s;
                    if (rd_n < N_READS) begin
                        check_eq("addr_a", addr_a, exp_q[rd_n].a);
                        check_eq("addr_b", addr_b, exp_q[rd_n].b);
                    end else begin
                        check_eq("extra_read", rd_n, N_READS - 1);
                    end
                    rd_n++;
                end
                check_eq("dv_align", data_valid, (s >= 3) ? hist[s-3] : 0);
                if (data_valid) begin
                    if (dv_n < N_READS) begin
                        check_eq("acc_clr", acc_clr, exp_q[dv_n].clr);
                        check_eq("acc_last", acc_last, exp_q[dv_n].last);
                        check_eq("head_idx", head_idx, exp_q[dv_n].h);
                        check_eq("ta_idx", ta_idx, exp_q[dv_n].ta);
                        check_eq("tb_idx", tb_idx, exp_q[dv_n].tb);
                    end
                    dv_n++;
                end
                if (done) begin
                    done_n++;
                    done_s = s;
                    check_eq("busy_at_done", busy, 0);
                    fin = 1'b1;
                end
            end
            start = 1'b0;
            abort = 1'b0;
            issue_ready = next_ready(rdy_mode, s);
            if (s == restart_s) start = 1'b1;
            if (kill_s < 0 && abort_at >= 0 && rd_n == abort_at) begin
                abort  = 1'b1;
                kill_s = s + 1;
            end
            if (kill_s < 0 && rst_at >= 0 && rd_n == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_quiet("in_reset");
                check_eq("in_reset_addr_a", addr_a, 0);
                check_eq("in_reset_addr_b", addr_b, 0);
                check_eq("in_reset_acc_clr", acc_clr, 0);
                kill_s  = s + 1;
                use_rst = 1'b1;
            end
        end
        check_eq("job_finished", fin, 1);
        if (kill_s >= 0) begin
            check_eq("reads_before_kill", rd_n, (abort_at >= 0) ? abort_at : rst_at);
            check_eq("no_done_after_kill", done_n, 0);
        end else begin
            check_eq("read_count", rd_n, N_READS);
            check_eq("dv_count", dv_n, N_READS);
            check_eq("done_count", done_n, 1);
            check_eq("done_latency", done_s - last_s, RD_LATENCY + 1);
            if (rdy_mode == 0) check_eq("first_rd_latency", first_s, 2);
            if (rdy_mode == 1) check_eq("toggle_span", last_s - first_s, 2 * (N_READS - 1));
            @(negedge clk);
            check_eq("done_one_cycle", done, 0);
            check_eq("idle_busy", busy, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check_eq("reset_addr_a", addr_a, 0);
        check_eq("reset_addr_b", addr_b, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("post_reset");

        run_job(0, 0, -1, -1, -1);
        run_job(1, 0, -1, -1, -1);
        run_job(0, 1, -1, -1, -1);
        run_job(0, 0, 40, -1, -1);
        run_job(0, 0, -1, -1, -1);
        run_job(1, 2, -1, -1, 20);
        run_job(0, 0, -1, 70, -1);
        for (int j = 0; j < 3; j++) run_job(int'($urandom_range(0, 1)), 2, -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
